// File: rtl/reg_dump_reader_if.sv
// Bundles the register-dump control, bank read port and output stream.
// slave is the dump engine's view; master is the driver/consumer side.
interface reg_dump_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              start;
  logic              pause;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_index;
  logic [DATA_W-1:0] out_data;
  logic              busy;
  logic              cpu_stall;
  logic              done;

  modport slave (
    input  start, pause, rd_data, out_ready,
    output rd_addr, out_valid, out_index, out_data, busy, cpu_stall, done
  );

  modport master (
    output start, pause, rd_data, out_ready,
    input  rd_addr, out_valid, out_index, out_data, busy, cpu_stall, done
  );
endinterface

// File: rtl/reg_dump_reader.sv
// Debug read-out engine: walks the register bank from FIRST_REG to LAST_REG and
// streams each captured value with its index over a valid/ready handshake.
module reg_dump_reader #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic              clk,
  input  logic              reset,
  reg_dump_reader_if.slave  bus
);

  localparam logic [ADDR_W-1:0] FirstIdx = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(LAST_REG);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              outValid_q, outValid_d;
  logic [ADDR_W-1:0] outIndex_q, outIndex_d;
  logic [DATA_W-1:0] outData_q, outData_d;
  logic [ADDR_W-1:0] rdAddr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      idx_q      <= FirstIdx;
      outValid_q <= 1'b0;
      outIndex_q <= '0;
      outData_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      outValid_q <= outValid_d;
      outIndex_q <= outIndex_d;
      outData_q  <= outData_d;
    end
  end

  // The index stops at LastIdx instead of incrementing, so it can never wrap.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    outValid_d = outValid_q;
    outIndex_d = outIndex_q;
    outData_d  = outData_q;
    rdAddr     = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          idx_d   = FirstIdx;
          state_d = FETCH;
        end
      end
      FETCH: begin
        rdAddr = idx_q;
        if (!bus.pause) begin
          outData_d  = bus.rd_data;
          outIndex_d = idx_q;
          outValid_d = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        rdAddr = idx_q;
        if (bus.out_ready) begin
          outValid_d = 1'b0;
          if (idx_q == LastIdx) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.rd_addr   = rdAddr;
  assign bus.out_valid = outValid_q;
  assign bus.out_index = outIndex_q;
  assign bus.out_data  = outData_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.cpu_stall = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: full dump, backpressure, pause, reset
// mid-dump, ignored restarts, held start and a single-register range.
module tb_reg_dump_reader;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   xfers = 0;
  int   dones = 0;
  logic [31:0] bank [32];

  reg_dump_reader_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();
  reg_dump_reader_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();

  reg_dump_reader #(.DATA_W(32), .ADDR_W(5), .FIRST_REG(0), .LAST_REG(31)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  reg_dump_reader #(.DATA_W(32), .ADDR_W(5), .FIRST_REG(31), .LAST_REG(31)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  assign bus0.rd_data = bank[bus0.rd_addr];
  assign bus1.rd_data = bank[bus1.rd_addr];

  always #5 clk = ~clk;

  // Independent tally of accepted transfers and done pulses on the full-range instance.
  always @(posedge clk) begin
    if (reset) begin
      if (bus0.out_valid && bus0.out_ready) xfers = xfers + 1;
      if (bus0.done) dones = dones + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic r);
    bus0.start     = s;
    bus0.pause     = p;
    bus0.out_ready = r;
  endtask

  task automatic waitDone(input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (bus0.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("done_within_bound", 64'(seen), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) bank[i] = 32'hA000_0000 + 32'(i);
    applyStimulus(1'b0, 1'b0, 1'b1);
    bus1.start = 1'b0;
    bus1.pause = 1'b0;
    bus1.out_ready = 1'b1;
    repeat (2) @(negedge clk);

    checkOutput("rst_valid", 64'(bus0.out_valid), 64'd0);
    checkOutput("rst_busy", 64'(bus0.busy), 64'd0);
    checkOutput("rst_rd_addr", 64'(bus0.rd_addr), 64'd0);
    checkOutput("rst_index", 64'(bus0.out_index), 64'd0);
    checkOutput("rst_data", 64'(bus0.out_data), 64'd0);
    checkOutput("rst_done", 64'(bus0.done), 64'd0);
    checkOutput("rst_busy1", 64'(bus1.busy), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] full dump");
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    bus0.start = 1'b0;
    checkOutput("c1_busy", 64'(bus0.busy), 64'd1);
    checkOutput("c1_stall", 64'(bus0.cpu_stall), 64'd1);
    checkOutput("c1_valid", 64'(bus0.out_valid), 64'd0);
    checkOutput("c1_rd_addr", 64'(bus0.rd_addr), 64'd0);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      checkOutput($sformatf("send%0d_valid", k), 64'(bus0.out_valid), 64'd1);
      checkOutput($sformatf("send%0d_index", k), 64'(bus0.out_index), 64'(k));
      checkOutput($sformatf("send%0d_data", k), 64'(bus0.out_data), 64'(32'hA000_0000 + 32'(k)));
      @(negedge clk);
      if (k < 31) begin
        checkOutput($sformatf("fetch%0d_rd_addr", k + 1), 64'(bus0.rd_addr), 64'(k + 1));
      end else begin
        checkOutput("c65_done", 64'(bus0.done), 64'd1);
        checkOutput("c65_valid", 64'(bus0.out_valid), 64'd0);
      end
    end
    @(negedge clk);
    checkOutput("c66_busy", 64'(bus0.busy), 64'd0);
    checkOutput("c66_done", 64'(bus0.done), 64'd0);
    checkOutput("c66_rd_addr", 64'(bus0.rd_addr), 64'd0);

    $display("[TB] backpressure on r3");
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    bus0.start = 1'b0;
    repeat (7) @(negedge clk);
    checkOutput("bp_c8_index", 64'(bus0.out_index), 64'd3);
    bus0.out_ready = 1'b0;
    bank[3] = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp%0d_valid", i), 64'(bus0.out_valid), 64'd1);
      checkOutput($sformatf("bp%0d_index", i), 64'(bus0.out_index), 64'd3);
      checkOutput($sformatf("bp%0d_data", i), 64'(bus0.out_data), 64'h0000_0000_A000_0003);
      checkOutput($sformatf("bp%0d_rd_addr", i), 64'(bus0.rd_addr), 64'd3);
    end
    bank[3] = 32'hA000_0003;
    bus0.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_fetch4_valid", 64'(bus0.out_valid), 64'd0);
    checkOutput("bp_fetch4_rd_addr", 64'(bus0.rd_addr), 64'd4);
    @(negedge clk);
    checkOutput("bp_send4_index", 64'(bus0.out_index), 64'd4);
    checkOutput("bp_send4_data", 64'(bus0.out_data), 64'h0000_0000_A000_0004);
    waitDone(80);
    @(negedge clk);

    $display("[TB] pause in fetch of r7");
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    bus0.start = 1'b0;
    repeat (13) @(negedge clk);
    checkOutput("pz_c14_index", 64'(bus0.out_index), 64'd6);
    bus0.pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("pz%0d_rd_addr", i), 64'(bus0.rd_addr), 64'd7);
      checkOutput($sformatf("pz%0d_valid", i), 64'(bus0.out_valid), 64'd0);
      checkOutput($sformatf("pz%0d_busy", i), 64'(bus0.busy), 64'd1);
    end
    bus0.pause = 1'b0;
    @(negedge clk);
    checkOutput("pz_c19_valid", 64'(bus0.out_valid), 64'd1);
    checkOutput("pz_c19_index", 64'(bus0.out_index), 64'd7);
    checkOutput("pz_c19_data", 64'(bus0.out_data), 64'h0000_0000_A000_0007);
    waitDone(80);
    @(negedge clk);

    $display("[TB] reset during send of r10");
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    bus0.start = 1'b0;
    repeat (21) @(negedge clk);
    checkOutput("rs_c22_index", 64'(bus0.out_index), 64'd10);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rs_valid", 64'(bus0.out_valid), 64'd0);
    checkOutput("rs_busy", 64'(bus0.busy), 64'd0);
    checkOutput("rs_rd_addr", 64'(bus0.rd_addr), 64'd0);
    checkOutput("rs_index", 64'(bus0.out_index), 64'd0);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b1);
    @(negedge clk);
    bus0.start = 1'b0;
    checkOutput("rs_restart_rd_addr", 64'(bus0.rd_addr), 64'd0);
    @(negedge clk);
    checkOutput("rs_restart_index", 64'(bus0.out_index), 64'd0);
    checkOutput("rs_restart_data", 64'(bus0.out_data), 64'h0000_0000_A000_0000);
    waitDone(80);
    @(negedge clk);

    $display("[TB] start pulses while busy");
    xfers = 0;
    dones = 0;
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      bus0.start = (c == 5 || c == 40);
    end
    checkOutput("ign_xfers", 64'(xfers), 64'd32);
    checkOutput("ign_dones", 64'(dones), 64'd1);
    checkOutput("ign_busy", 64'(bus0.busy), 64'd0);

    $display("[TB] start held high");
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitDone(80);
    @(negedge clk);
    checkOutput("hold_idle_busy", 64'(bus0.busy), 64'd0);
    @(negedge clk);
    bus0.start = 1'b0;
    checkOutput("hold_retrig_busy", 64'(bus0.busy), 64'd1);
    waitDone(80);
    @(negedge clk);

    $display("[TB] single-register range");
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    checkOutput("one_c1_busy", 64'(bus1.busy), 64'd1);
    checkOutput("one_c1_rd_addr", 64'(bus1.rd_addr), 64'd31);
    @(negedge clk);
    checkOutput("one_c2_valid", 64'(bus1.out_valid), 64'd1);
    checkOutput("one_c2_index", 64'(bus1.out_index), 64'd31);
    checkOutput("one_c2_data", 64'(bus1.out_data), 64'h0000_0000_A000_001F);
    @(negedge clk);
    checkOutput("one_c3_done", 64'(bus1.done), 64'd1);
    checkOutput("one_c3_valid", 64'(bus1.out_valid), 64'd0);
    @(negedge clk);
    checkOutput("one_c4_busy", 64'(bus1.busy), 64'd0);
    checkOutput("one_c4_done", 64'(bus1.done), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
